// File: rtl/vfpu_lod_arbiter.sv
// Shared leading-one detector with a NUM_REQ:1 arbiter and a single-entry result register.
// Define VFPU_LOD_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module vfpu_lod_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned LW     = $clog2(WIDTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [IDW-1:0]             resp_id_o,
  output logic [LW-1:0]              resp_index_o,
  output logic                       resp_no_ones_o,
  output logic                       busy_o
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] req_data [NUM_REQ];
  logic [WIDTH-1:0] operand;
  logic [IDW-1:0]   grant_id;
  logic             grant_any;
  logic             slot_free;
  logic             accept;
  logic [LW-1:0]    lod_index;
  logic             lod_none;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_data[g] = req_data_i[g*WIDTH +: WIDTH];
  end

`ifdef VFPU_LOD_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && req_valid_i[IDW'(k)]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(k);
      end
    end
  end
`else
  logic [IDW-1:0] ptr;
  int unsigned    rr_idx;

  // Search upward from the pointer, wrapping at NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    rr_idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_idx = (32'(ptr) + k) % NUM_REQ;
      if (!grant_any && req_valid_i[IDW'(rr_idx)]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end
`endif

  assign operand = req_data[grant_id];

  // Leading one counted from the MSB; all-zero operand yields index 0.
  always_comb begin
    lod_index = '0;
    lod_none  = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (lod_none && operand[LW'(WIDTH - 1 - i)]) begin
        lod_none  = 1'b0;
        lod_index = LW'(i);
      end
    end
  end

  assign resp_valid_o = (state == FULL);
  assign slot_free    = (state == EMPTY) | (resp_valid_o & resp_ready_i);
  assign accept       = slot_free & grant_any & ~rst_i;
  assign busy_o       = resp_valid_o | (|req_valid_i);

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_ready_o[k] = accept && (grant_id == IDW'(k));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = FULL;
    end else if (state == FULL && resp_ready_i) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_id_o      <= '0;
      resp_index_o   <= '0;
      resp_no_ones_o <= 1'b0;
    end else if (accept) begin
      resp_id_o      <= grant_id;
      resp_index_o   <= lod_index;
      resp_no_ones_o <= lod_none;
    end
  end

endmodule

// File: tb/tb_vfpu_lod_arbiter.sv
// Directed self-checking bench for vfpu_lod_arbiter (honours VFPU_LOD_ARB_FIXED_PRIO_EN).
module tb_vfpu_lod_arbiter;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_REQ = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         d [NUM_REQ];
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [1:0]               resp_id;
  logic [4:0]               resp_index;
  logic                     resp_no_ones;
  logic                     busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign req_data = {d[3], d[2], d[1], d[0]};

  vfpu_lod_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_data_i     (req_data),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_id_o      (resp_id),
    .resp_index_o   (resp_index),
    .resp_no_ones_o (resp_no_ones),
    .busy_o         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_resp(input string tag, input logic [1:0] id, input logic [4:0] idx,
                            input logic none);
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_id"}, 32'(resp_id), 32'(id));
    check({tag, "_index"}, 32'(resp_index), 32'(idx));
    check({tag, "_none"}, 32'(resp_no_ones), 32'(none));
  endtask

  int unsigned rr_lod [NUM_REQ];
  int unsigned exp_id;

  initial begin
    rst        = 1'b1;
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) d[i] = '0;
    rr_lod = '{31, 1, 23, 0};

    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_id", 32'(resp_id), 32'h0);
    check("rst_index", 32'(resp_index), 32'h0);
    check("rst_none", 32'(resp_no_ones), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    rst       = 1'b0;
    req_valid = '0;
    #1;
    check("idle_busy", 32'(busy), 32'h0);

    // Port 0, bit 16 set -> index 15.
    d[0] = 32'h0001_0000;
    req_valid = 4'b0001;
    #1;
    check("p0_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check_resp("p0", 2'd0, 5'd15, 1'b0);
    tick();
    check("p0_drain", 32'(resp_valid), 32'h0);

    // Port 2, zero operand.
    d[2] = 32'h0;
    req_valid = 4'b0100;
    #1;
    check("p2_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    check_resp("p2", 2'd2, 5'd0, 1'b1);
    tick();

    // Fill with port 1, then reset while FULL.
    d[1] = 32'h8000_0000;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    check_resp("p1", 2'd1, 5'd0, 1'b0);
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    check("midrst_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    check("midrst_valid", 32'(resp_valid), 32'h0);
    tick();
    check("postrst_valid", 32'(resp_valid), 32'h0);

    // All ports valid every cycle with the consumer always ready.
    d[0] = 32'h0000_0001;
    d[1] = 32'h4000_0000;
    d[2] = 32'h0000_0100;
    d[3] = 32'hFFFF_FFFF;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
`ifdef VFPU_LOD_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = k % NUM_REQ;
`endif
      #1;
      check($sformatf("rr%0d_ready", k), 32'(req_ready), 32'h1 << exp_id);
      tick();
      check_resp($sformatf("rr%0d", k), 2'(exp_id), 5'(rr_lod[exp_id]), 1'b0);
    end

    // Back-pressure: result held and nothing accepted.
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("hold%0d_ready", k), 32'(req_ready), 32'h0);
      tick();
      check_resp($sformatf("hold%0d", k), 2'd0, 5'd31, 1'b0);
    end

    // Release: drain and accept in the same cycle.
    resp_ready = 1'b1;
`ifdef VFPU_LOD_ARB_FIXED_PRIO_EN
    exp_id = 0;
`else
    exp_id = 1;
`endif
    #1;
    check("rel_ready", 32'(req_ready), 32'h1 << exp_id);
    tick();
    req_valid = '0;
    check_resp("rel", 2'(exp_id), 5'(rr_lod[exp_id]), 1'b0);
    check("rel_busy", 32'(busy), 32'h1);
    tick();
    check("final_valid", 32'(resp_valid), 32'h0);
    check("final_busy", 32'(busy), 32'h0);

`ifdef VFPU_LOD_ARB_FIXED_PRIO_EN
    // Ports 1 and 3 always valid: port 1 must win every cycle.
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("fp%0d_ready", k), 32'(req_ready), 32'h2);
      tick();
      check_resp($sformatf("fp%0d", k), 2'd1, 5'd1, 1'b0);
    end
    req_valid = '0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
